four_bank_mem_resp: RTL and testbench

//  Memory-side responder for the cache controller's fill/writeback protocol (wr, rd, addr, stall).
//  - Four word-interleaved banks.
//  - A bank is occupied for BANK_CYCLES after each access.
//  - A request to an occupied bank is stalled.
//  - Read data returns a fixed 2 cycles after acceptance.
//  - Sits between the cache FSM and the backing store; back-to-back offsets 0..3 stream with no stall.

---
 rtl/mem_resp_pkg.sv | 14 +
 rtl/mem_bank.sv | 61 ++++++
 rtl/four_bank_mem_resp.sv | 98 +++++++++
 tb/tb_four_bank_mem_resp.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared constants, bank index type and bank decode helper
package mem_resp_pkg;

  localparam int NUM_BANKS = 4;
  localparam int RD_LAT    = 2;

  typedef logic [1:0] bank_idx_t;

  // Word-interleaved banking: consecutive 16-bit words map to consecutive banks.
  function automatic bank_idx_t bank_of(input logic [2:1] addr_lo);
    return addr_lo;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// rtl/mem_bank.sv - one bank: storage array, occupancy counter, busy flag, read-sample register
module mem_bank
  import mem_resp_pkg::*;
#(
  parameter int RW          = 13,
  parameter int DW          = 16,
  parameter int BANK_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc_i,
  input  logic          we_i,
  input  logic [RW-1:0] row_i,
  input  logic [DW-1:0] wdata_i,
  output logic          busy_o,
  output logic [DW-1:0] rdata_o
);

  localparam int            CW       = $clog2(BANK_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BANK_CYCLES - 1);

  logic [DW-1:0] mem_q [2**RW];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;

  // Storage write port; deliberately unreset so contents survive rst.
  always_ff @(posedge clk) begin
    if (acc_i && we_i) begin
      mem_q[row_i] <= wdata_i;
    end
  end

  // Next state: reload the occupancy count on access, else count down and hold at zero.
  always_comb begin
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    if (acc_i) begin
      cnt_d = CNT_LOAD;
      if (!we_i) begin
        rdata_d = mem_q[row_i];
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Counter and read-sample registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy_o  = (cnt_q != '0);
  assign rdata_o = rdata_q;

endmodule

// File: rtl/four_bank_mem_resp.sv
// rtl/four_bank_mem_resp.sv - four-bank interleaved memory responder; optional MEM_ERR_EN protocol check
module four_bank_mem_resp
  import mem_resp_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int BANK_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        data_in,
  input  logic                 wr,
  input  logic                 rd,
  output logic [DW-1:0]        data_out,
  output logic                 rd_valid,
  output logic                 stall,
  output logic [NUM_BANKS-1:0] busy,
  output logic                 err
);

  localparam int RW = AW - 3;

  bank_idx_t            bank_w;
  logic                 req_w;
  logic                 illegal_w;
  logic                 acc_w;
  logic                 is_rd_w;
  logic [NUM_BANKS-1:0] busy_w;
  logic [DW-1:0]        rdata_w [NUM_BANKS];

  logic [RD_LAT-1:0]    vld_q, vld_d;
  bank_idx_t            s1_bank_q, s1_bank_d;
  logic [DW-1:0]        data_out_q, data_out_d;
  logic                 err_q, err_d;

  assign req_w  = rd | wr;
  assign bank_w = bank_of(addr[2:1]);

`ifdef MEM_ERR_EN
  assign illegal_w = (rd & wr) | addr[0];
`else
  logic unused_addr0;
  assign unused_addr0 = addr[0];
  assign illegal_w    = 1'b0;
`endif

  // Illegal requests never stall and never touch a bank; rd&wr otherwise resolves to a write.
  assign stall   = req_w & ~illegal_w & busy_w[bank_w];
  assign acc_w   = req_w & ~illegal_w & ~busy_w[bank_w];
  assign is_rd_w = rd & ~wr;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    mem_bank #(
      .RW         (RW),
      .DW         (DW),
      .BANK_CYCLES(BANK_CYCLES)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .acc_i  (acc_w && (bank_w == bank_idx_t'(i))),
      .we_i   (wr),
      .row_i  (addr[AW-1:3]),
      .wdata_i(data_in),
      .busy_o (busy_w[i]),
      .rdata_o(rdata_w[i])
    );
  end

  // Return pipe: stage 1 is the bank's sample register, stage 2 selects it onto data_out.
  always_comb begin
    vld_d      = {vld_q[RD_LAT-2:0], acc_w & is_rd_w};
    s1_bank_d  = (acc_w & is_rd_w) ? bank_w : s1_bank_q;
    data_out_d = vld_q[0] ? rdata_w[s1_bank_q] : '0;
    err_d      = req_w & illegal_w;
  end

  // Pipe and error registers; reset drops any read in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      s1_bank_q  <= '0;
      data_out_q <= '0;
      err_q      <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      s1_bank_q  <= s1_bank_d;
      data_out_q <= data_out_d;
      err_q      <= err_d;
    end
  end

  assign busy     = busy_w;
  assign rd_valid = vld_q[RD_LAT-1];
  assign data_out = data_out_q;
  assign err      = err_q;

endmodule

// File: tb/tb_four_bank_mem_resp.sv
// tb/tb_four_bank_mem_resp.sv - randomized self-checking bench with a cycle-level reference model
module tb_four_bank_mem_resp;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BC = 4;

`ifdef MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic          wr;
  logic          rd;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          stall;
  logic [3:0]    busy;
  logic          err;

  four_bank_mem_resp #(.AW(AW), .DW(DW), .BANK_CYCLES(BC)) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .data_in (data_in),
    .wr      (wr),
    .rd      (rd),
    .data_out(data_out),
    .rd_valid(rd_valid),
    .stall   (stall),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } ret_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            free_at [4];
  logic [DW-1:0] ref_mem [int];
  ret_t          rq [$];
  logic [DW-1:0] obs_q [$];
  bit            err_exp = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: present a request, check every output against the model, advance the model.
  task automatic tick(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output bit acc, output bit stl);
    logic [3:0]    eb;
    bit            req, ill, erv;
    logic [DW-1:0] edo;
    int            b, key;
    rd = r; wr = w; addr = a; data_in = d;
    @(negedge clk);
    b = int'(a[2:1]);
    for (int i = 0; i < 4; i++) eb[i] = (cyc < free_at[i]);
    req = r || w;
    ill = ERR_EN && ((r && w) || (a[0] == 1'b1));
    stl = req && !ill && eb[b];
    erv = 1'b0;
    edo = '0;
    if (rq.size() > 0) begin
      if (rq[0].due == cyc) begin
        erv = 1'b1;
        edo = rq[0].data;
      end
    end
    check_eq("busy", 32'(busy), 32'(eb));
    check_eq("stall", 32'(stall), 32'(stl));
    check_eq("rd_valid", 32'(rd_valid), 32'(erv));
    check_eq("data_out", 32'(data_out), 32'(edo));
    check_eq("err", 32'(err), 32'(err_exp));
    if (rd_valid) obs_q.push_back(data_out);
    if (erv) rq.delete(0);
    err_exp = req && ill;
    acc = req && !ill && !stl;
    if (acc) begin
      free_at[b] = cyc + BC;
      key = int'(a[AW-1:1]);
      if (w) ref_mem[key] = d;
      else   rq.push_back('{due: cyc + 2, data: (ref_mem.exists(key) ? ref_mem[key] : '0)});
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc, stl;
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, '0, '0, acc, stl);
  endtask

  // Present a request and hold it while stalled, with a bounded wait.
  task automatic issue(input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int nstall);
    bit acc, stl;
    nstall = 0;
    for (int k = 0; k < 16; k++) begin
      tick(r, w, a, d, acc, stl);
      if (!stl) return;
      nstall++;
    end
    check_eq("hold_timeout", 32'(stall), 32'(0));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    rd = 1'b0; wr = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_rd_valid", 32'(rd_valid), 32'(0));
    check_eq("rst_data_out", 32'(data_out), 32'(0));
    check_eq("rst_err", 32'(err), 32'(0));
    rq.delete();
    err_exp = 1'b0;
    for (int i = 0; i < 4; i++) free_at[i] = 0;
    @(negedge clk);
    check_eq("rst_hold_rd_valid", 32'(rd_valid), 32'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] t3_exp [4];
    bit            acc, stl;
    int            ns;
    bit            have_req;
    logic          pr, pw;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    int            op;

    rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    for (int i = 0; i < 4; i++) free_at[i] = 0;
    t3_exp[0] = 16'h1111; t3_exp[1] = 16'h2222; t3_exp[2] = 16'h3333; t3_exp[3] = 16'h4444;

    // Reset, then five idle cycles.
    @(posedge clk);
    #1;
    do_reset();
    idle(5);

    // Writes to all four banks on consecutive cycles.
    tick(1'b0, 1'b1, 16'h0000, 16'h1111, acc, stl);
    tick(1'b0, 1'b1, 16'h0002, 16'h2222, acc, stl);
    tick(1'b0, 1'b1, 16'h0004, 16'h3333, acc, stl);
    tick(1'b0, 1'b1, 16'h0006, 16'h4444, acc, stl);

    // Back-to-back reads stream out in order.
    obs_q.delete();
    tick(1'b1, 1'b0, 16'h0000, '0, acc, stl);
    tick(1'b1, 1'b0, 16'h0002, '0, acc, stl);
    tick(1'b1, 1'b0, 16'h0004, '0, acc, stl);
    tick(1'b1, 1'b0, 16'h0006, '0, acc, stl);
    idle(4);
    check_eq("t3_count", 32'(obs_q.size()), 32'(4));
    for (int i = 0; i < 4; i++) begin
      if (i < obs_q.size()) check_eq("t3_data", 32'(obs_q[i]), 32'(t3_exp[i]));
    end

    // Same-bank read right after a write is held for BC-1 cycles.
    idle(4);
    obs_q.delete();
    tick(1'b0, 1'b1, 16'h0008, 16'h5555, acc, stl);
    issue(1'b1, 1'b0, 16'h0000, '0, ns);
    check_eq("t4_stalls", 32'(ns), 32'(BC - 1));
    idle(3);
    check_eq("t4_count", 32'(obs_q.size()), 32'(1));
    if (obs_q.size() > 0) check_eq("t4_data", 32'(obs_q[0]), 32'h1111);

    // Reset while a read is in flight: it is dropped, storage survives.
    idle(4);
    obs_q.delete();
    tick(1'b1, 1'b0, 16'h0002, '0, acc, stl);
    do_reset();
    idle(3);
    check_eq("t5_dropped", 32'(obs_q.size()), 32'(0));
    issue(1'b1, 1'b0, 16'h0002, '0, ns);
    idle(3);
    check_eq("t5_count", 32'(obs_q.size()), 32'(1));
    if (obs_q.size() > 0) check_eq("t5_data", 32'(obs_q[0]), 32'h2222);

`ifdef MEM_ERR_EN
    // Illegal requests: flagged next cycle, no access, no response.
    idle(4);
    obs_q.delete();
    tick(1'b1, 1'b1, 16'h0004, 16'hdead, acc, stl);
    check_eq("t6_rw_err", 32'(err), 32'(1));
    check_eq("t6_rw_busy", 32'(busy), 32'(0));
    tick(1'b1, 1'b0, 16'h0001, '0, acc, stl);
    check_eq("t6_odd_err", 32'(err), 32'(1));
    idle(3);
    check_eq("t6_no_rv", 32'(obs_q.size()), 32'(0));
    issue(1'b1, 1'b0, 16'h0004, '0, ns);
    idle(3);
    check_eq("t6_row_kept", 32'(obs_q.size() > 0 ? obs_q[0] : 16'h0000), 32'h3333);
`endif

    // Fill a small window of rows so every random read hits known data.
    for (int rw = 0; rw < 8; rw++) begin
      for (int bk = 0; bk < 4; bk++) begin
        issue(1'b0, 1'b1, AW'((rw << 3) | (bk << 1)), DW'($urandom), ns);
      end
    end

    // Random traffic; stalled requests are held unchanged until accepted.
    have_req = 1'b0;
    pr = 1'b0; pw = 1'b0; pa = '0; pd = '0;
    for (int n = 0; n < 400; n++) begin
      if (!have_req) begin
        op = int'($urandom_range(0, 9));
        pr = (op >= 3 && op <= 5) || (op == 9);
        pw = (op >= 6);
        pa = AW'(($urandom_range(0, 7) << 3) | ($urandom_range(0, 3) << 1) |
                 (($urandom_range(0, 7) == 0) ? 1 : 0));
        pd = DW'($urandom);
      end
      tick(pr, pw, pa, pd, acc, stl);
      have_req = stl;
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
